// File: rtl/muldiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : muldiv_pkg                                            |
// | Purpose  : Shared operation encodings and FSM state type for the |
// |            iterative multiply/divide unit.                       |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package muldiv_pkg;

  // Operation select as presented on the func input.
  typedef enum logic [1:0] {
    FUNC_MULTU = 2'b00,
    FUNC_MULT  = 2'b01,
    FUNC_DIVU  = 2'b10,
    FUNC_DIV   = 2'b11
  } func_e;

  // Sequencer states: wait, iterate, finalise.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Bit 0 of the encoding marks the signed variants.
  function automatic logic func_is_signed(input func_e f);
    return f[0];
  endfunction

  // Bit 1 of the encoding marks the divide variants.
  function automatic logic func_is_div(input func_e f);
    return f[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : muldiv_if                                             |
// | Purpose  : Request/result bundle between the execute stage and   |
// |            the multiply/divide unit.                             |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  // Requester side: issues operations, observes results.
  modport master (
    output start, func, a, b,
    input  hi, lo, busy, done
  );

  // Unit side: accepts operations, presents results.
  modport slave (
    input  start, func, a, b,
    output hi, lo, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : muldiv_iter                                           |
// | Purpose  : One combinational step of shift-add multiply or       |
// |            restoring divide on a 2*WIDTH+1 bit accumulator.      |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
// Accumulator layout, both modes:
//   [2W:W]   upper part (multiply: running partial product with carry,
//            divide: partial remainder)
//   [W-1:0]  lower part (multiply: remaining multiplier bits shifting out
//            while product bits shift in, divide: dividend bits shifting
//            out while quotient bits shift in)
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  wire logic [2*WIDTH:0] i_acc,
  input  wire logic             i_is_div,
  input  wire logic [WIDTH-1:0] i_operand,
  output logic      [2*WIDTH:0] o_acc
);

  logic [WIDTH:0]   w_add_sum;
  logic [2*WIDTH:0] w_shl;
  logic [WIDTH:0]   w_trial;

  // Select between the multiply step (conditional add then shift right)
  // and the divide step (shift left then trial subtract).
  always_comb begin
    // In multiply mode the top bit is always clear on entry, so it can be
    // carried through the add without changing the sum.
    w_add_sum = i_acc[2*WIDTH:WIDTH] + {1'b0, i_operand};
    w_shl     = {i_acc[2*WIDTH-1:0], 1'b0};
    // The remainder stays below the divisor, so after the shift it fits in
    // WIDTH+1 bits and bit WIDTH of the difference is a clean borrow flag.
    w_trial   = w_shl[2*WIDTH:WIDTH] - {1'b0, i_operand};
    o_acc     = i_acc;
    if (i_is_div) begin
      if (w_trial[WIDTH]) begin
        o_acc = w_shl;
      end else begin
        o_acc = {w_trial, w_shl[WIDTH-1:1], 1'b1};
      end
    end else if (i_acc[0]) begin
      o_acc = {1'b0, w_add_sum, i_acc[WIDTH-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[2*WIDTH:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : muldiv_unit                                           |
// | Purpose  : Iterative signed/unsigned multiply and divide with a  |
// |            start/busy/done handshake and HI/LO result registers. |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
// WIDTH must be at least 4.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input wire logic clk,
  input wire logic resetn,
  muldiv_if.slave  bus
);

  localparam int                 c_cnt_w     = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);
  localparam int                 c_acc_w     = 2 * WIDTH + 1;

  state_e             r_state;
  state_e             w_state_next;
  logic [c_cnt_w-1:0] r_cnt;

  func_e              r_func;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [c_acc_w-1:0] r_acc;
  logic [c_acc_w-1:0] w_acc_next;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_busy;
  logic               w_load;
  logic               w_step;
  logic               w_fix;

  func_e              w_func_in;
  logic               w_sign_a_in;
  logic               w_sign_b_in;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_signed_op;
  logic               w_neg_res;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;
  logic               w_unused_acc_msb;

  // Magnitudes of the incoming operands; the most-negative value maps to
  // its own unsigned bit pattern, which is the correct magnitude.
  assign w_func_in   = func_e'(bus.func);
  assign w_sign_a_in = func_is_signed(w_func_in) & bus.a[WIDTH-1];
  assign w_sign_b_in = func_is_signed(w_func_in) & bus.b[WIDTH-1];
  assign w_mag_a     = w_sign_a_in ? (~bus.a + 1'b1) : bus.a;
  assign w_mag_b     = w_sign_b_in ? (~bus.b + 1'b1) : bus.b;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: fixed WIDTH iterations then one finalise cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = CALC;
      CALC:    if (r_cnt == c_last_iter) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs driving the datapath enables.
  always_comb begin
    w_busy = (r_state != IDLE);
    w_load = (r_state == IDLE) && bus.start;
    w_step = (r_state == CALC);
    w_fix  = (r_state == FIX);
  end

  // Iteration counter, cleared on load and after the last iteration.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= (r_cnt == c_last_iter) ? '0 : r_cnt + c_cnt_w'(1);
    end
  end

  // Operand latches; inputs are free to change after the start edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_func   <= FUNC_MULTU;
      r_a_raw  <= '0;
      r_opnd   <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
    end else if (w_load) begin
      r_func   <= w_func_in;
      r_a_raw  <= bus.a;
      r_opnd   <= w_mag_b;
      r_sign_a <= w_sign_a_in;
      r_sign_b <= w_sign_b_in;
    end
  end

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .i_acc     (r_acc),
    .i_is_div  (func_is_div(r_func)),
    .i_operand (r_opnd),
    .o_acc     (w_acc_next)
  );

  // Accumulator: seeded with |a| in the low half for both modes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
    end else if (w_load) begin
      r_acc <= {{(WIDTH + 1){1'b0}}, w_mag_a};
    end else if (w_step) begin
      r_acc <= w_acc_next;
    end
  end

  // Sign correction and divide-by-zero handling applied in the FIX cycle.
  always_comb begin
    w_prod      = r_acc[2*WIDTH-1:0];
    w_quo       = r_acc[WIDTH-1:0];
    w_rem       = r_acc[2*WIDTH-1:WIDTH];
    w_signed_op = func_is_signed(r_func);
    w_neg_res   = w_signed_op & (r_sign_a ^ r_sign_b);
    w_div_zero  = (r_opnd == '0);
    w_hi_fix    = '0;
    w_lo_fix    = '0;
    if (!func_is_div(r_func)) begin
      if (w_neg_res) begin
        w_prod = ~w_prod + 1'b1;
      end
      w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod[WIDTH-1:0];
    end else if (w_div_zero) begin
      w_hi_fix = r_a_raw;
      w_lo_fix = '1;
    end else begin
      // Most-negative / -1 falls out naturally: |q| = 2^(W-1), no negation.
      w_lo_fix = w_neg_res ? (~w_quo + 1'b1) : w_quo;
      w_hi_fix = (w_signed_op && r_sign_a) ? (~w_rem + 1'b1) : w_rem;
    end
  end

  // Result registers and the one-cycle done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_fix) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end

  // The accumulator top bit only carries intermediate state.
  assign w_unused_acc_msb = r_acc[2*WIDTH];

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = w_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the CPU execute stage. It computes signed and unsigned multiply and divide over WIDTH-bit operands with a start/busy/done handshake, and writes its results to dedicated HI/LO registers. It replaces a fixed-width, purely combinational result selector with a single shared sequential datapath.

## Interface
- WIDTH, 32, operand and HI/LO width; must be at least 4.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only while idle.
- func  in  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- hi  out  WIDTH  upper product half, or remainder.
- lo  out  WIDTH  lower product half, or quotient.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo have just been updated.

## Operation
- The FSM has three states.
  - IDLE: waits for start.
  - CALC: WIDTH iterations, one per cycle.
  - FIX: one cycle for sign correction and special cases.
- IDLE with start=1: latch func, a and b, then go to CALC.
  - Signed ops (01, 11) latch magnitudes plus the sign bits.
  - The magnitude of the most-negative value is its unsigned bit pattern, so no width extension is needed.
- Multiply: shift-add on magnitudes into a 2*WIDTH accumulator. For mult, FIX negates the product when sign(a) XOR sign(b) is set.
- Divide: restoring division on magnitudes, one quotient bit per cycle, with a (WIDTH+1)-bit partial remainder.
  - For div, the quotient is negated when the operand signs differ. The quotient truncates toward zero.
  - For div, the remainder takes the sign of the dividend.
- Divide by zero (b==0, divu or div): lo = all ones, hi = a as latched (original value, not its magnitude). No trap is raised.
- Signed overflow, most-negative / −1: lo = most-negative value, hi = 0. This is the natural wrap result; no flag is raised.
- FIX writes hi/lo, then the FSM returns to IDLE.
- hi/lo hold their value until the next FIX.

## Timing
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, counter 0.
- Latency, with the start-sampling edge as E0:
  - busy goes to 1 after E0.
  - CALC occupies edges E1..E(WIDTH).
  - FIX occupies edge E(WIDTH+1).
  - After E(WIDTH+1), busy=0, done=1 and hi/lo hold the new values.
  - busy is therefore high for exactly WIDTH+1 cycles. For WIDTH=32, results appear 33 cycles after the start edge.
- done is high for exactly one cycle.
- The earliest next start is sampled on the same cycle that done is high, which gives back-to-back operation.
- start while busy=1 is ignored; no queuing.
- func, a and b may change freely after E0.
- Reset asserted mid-operation: the operation is aborted immediately, all outputs return to their reset values, and no done pulse is produced.
- The latency is data-independent for all cases, including divide by zero and zero operands; there is no early termination.

## Structure
- Shared package muldiv_pkg:
  - func encodings FUNC_MULTU, FUNC_MULT, FUNC_DIVU, FUNC_DIV;
  - state enum IDLE/CALC/FIX.
- muldiv_unit contains the FSM, the iteration counter (ceil(log2(WIDTH)) bits, wide enough to count WIDTH iterations), operand latches and the FIX logic.
- Natural sub-module: muldiv_iter. It is the combinational single-iteration step, taking the accumulator, the mode and the latched divisor or multiplier and producing the next accumulator. This keeps the FSM file small and lets the step be unit-tested.

## Test plan
All scenarios use WIDTH=32.
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done 33 cycles after the start edge; busy high for 33 cycles.
- mult a=−3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- divu a=100 b=7 -> lo=14, hi=2.
- div a=−7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Special cases:
  - divu a=5 b=0 -> lo=0xFFFFFFFF, hi=5.
  - div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake and reset:
  - Pulse start again during busy with different operands: it is ignored and the first result is unchanged.
  - Assert resetn low at cycle 10 of an operation: busy=0, hi=lo=0, no done pulse.
  - A subsequent multu 6×7 then gives lo=42, hi=0.
  - A back-to-back start on the done cycle gives a correct second result 33 cycles later.
